sel8_rr_arbiter: RTL and testbench

- Round-robin arbiter sharing one 8-way select resource between 8 requesters.
- Produces a registered 3-bit select index and an 8-bit one-hot grant. The grant polarity is chosen by i_opt with the same convention as the 3-8 decoder blocks: 1 = active-high one-hot, 0 = active-low one-cold.
- Sits between requesting masters and the shared mux/decoder path; guarantees non-overlapping grants with a one-cycle gap.

---
 rtl/sel8_rr_arbiter.sv | 127 ++++++++++++
 tb/tb_sel8_rr_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/sel8_rr_arbiter.sv
// Round-robin arbiter for one shared 8-way select: registered index/valid, one-hot or one-cold grant.
// Optional hold timeout is compiled in with SEL8_ARB_TIMEOUT_EN (bounds each tenure to MAX_HOLD cycles).
module sel8_rr_arbiter #(
   parameter int MAX_HOLD = 16
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_req,
   input  logic       i_opt,
   output logic [7:0] o_gnt,
   output logic [2:0] o_sel,
   output logic       o_valid,
   output logic       o_timeout
);

   typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

   state_t     state, state_nxt;
   logic [2:0] ptr, ptr_nxt;
   logic [2:0] sel_nxt;
   logic       valid_nxt;
   logic       tmo_nxt;
   logic [2:0] winner;
   logic [2:0] idx;
   logic       found;
   logic [7:0] gnt_hi;

   generate
      if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_hold
         $error("sel8_rr_arbiter: MAX_HOLD out of range 2..256");
      end
   endgenerate

`ifdef SEL8_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(MAX_HOLD);
   logic [CNT_W-1:0] cnt, cnt_nxt;
`endif

   // Rotating search: first set request at or after ptr, wrapping mod 8.
   always_comb begin
      found  = 1'b0;
      winner = ptr;
      idx    = ptr;
      for (int i = 0; i < 8; i++) begin
         idx = ptr + 3'(i);
         if (!found && i_req[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      sel_nxt   = o_sel;
      valid_nxt = o_valid;
      tmo_nxt   = 1'b0;
`ifdef SEL8_ARB_TIMEOUT_EN
      cnt_nxt   = cnt;
`endif
      case (state)
         BUSY: begin
            if (!i_req[o_sel]) begin
               state_nxt = GAP;
               valid_nxt = 1'b0;
               ptr_nxt   = o_sel + 3'd1;
`ifdef SEL8_ARB_TIMEOUT_EN
            end else if (cnt == CNT_W'(MAX_HOLD - 1)) begin
               // Forced release: same bookkeeping as a normal one, plus the pulse.
               state_nxt = GAP;
               valid_nxt = 1'b0;
               ptr_nxt   = o_sel + 3'd1;
               tmo_nxt   = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
`endif
            end
         end
         default: begin
            if (found) begin
               state_nxt = BUSY;
               sel_nxt   = winner;
               valid_nxt = 1'b1;
`ifdef SEL8_ARB_TIMEOUT_EN
               cnt_nxt   = '0;
`endif
            end else begin
               state_nxt = IDLE;
               valid_nxt = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= IDLE;
         ptr       <= 3'd0;
         o_sel     <= 3'd0;
         o_valid   <= 1'b0;
         o_timeout <= 1'b0;
`ifdef SEL8_ARB_TIMEOUT_EN
         cnt       <= '0;
`endif
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         o_sel     <= sel_nxt;
         o_valid   <= valid_nxt;
         o_timeout <= tmo_nxt;
`ifdef SEL8_ARB_TIMEOUT_EN
         cnt       <= cnt_nxt;
`endif
      end
   end

   // Grant decode per bit; i_opt only flips polarity, so it acts without a clock edge.
   generate
      for (genvar b = 0; b < 8; b++) begin : g_gnt
         assign gnt_hi[b] = o_valid && (o_sel == 3'(b));
      end
   endgenerate

   assign o_gnt = i_opt ? gnt_hi : ~gnt_hi;

endmodule

// File: tb/tb_sel8_rr_arbiter.sv
// Directed bench for sel8_rr_arbiter; timeout vectors run only when SEL8_ARB_TIMEOUT_EN is defined.
module tb_sel8_rr_arbiter;

   logic       i_clk = 1'b0;
   logic       i_rst;
   logic [7:0] i_req;
   logic       i_opt;
   logic [7:0] o_gnt;
   logic [2:0] o_sel;
   logic       o_valid;
   logic       o_timeout;

   int n_chk  = 0;
   int n_fail = 0;

   sel8_rr_arbiter #(.MAX_HOLD(16)) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_req     (i_req),
      .i_opt     (i_opt),
      .o_gnt     (o_gnt),
      .o_sel     (o_sel),
      .o_valid   (o_valid),
      .o_timeout (o_timeout)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk_st(input string tag, input logic [7:0] gnt, input logic [2:0] sel,
                         input logic vld, input logic tmo);
      chk({tag, ".gnt"}, o_gnt, gnt);
      chk({tag, ".sel"}, {5'd0, o_sel}, {5'd0, sel});
      chk({tag, ".vld"}, {7'd0, o_valid}, {7'd0, vld});
      chk({tag, ".tmo"}, {7'd0, o_timeout}, {7'd0, tmo});
   endtask

   initial begin
      i_rst = 1'b1;
      i_req = 8'h00;
      i_opt = 1'b1;
      tick();
      tick();
      i_rst = 1'b0;
      chk_st("reset", 8'h00, 3'd0, 1'b0, 1'b0);
      i_opt = 1'b0;
      #1;
      chk("reset_cold", o_gnt, 8'hFF);
      i_opt = 1'b1;
      #1;

      // Wrap-around of the pointer
      i_req = 8'h81;
      tick();
      chk_st("g0", 8'h01, 3'd0, 1'b1, 1'b0);
      i_req = 8'h80;
      tick();
      chk_st("gap0", 8'h00, 3'd0, 1'b0, 1'b0);
      tick();
      chk_st("g7", 8'h80, 3'd7, 1'b1, 1'b0);
      i_req = 8'h01;
      tick();
      chk_st("gap7", 8'h00, 3'd7, 1'b0, 1'b0);
      tick();
      chk_st("g0_wrap", 8'h01, 3'd0, 1'b1, 1'b0);

      // Active-low grant, no preemption, live polarity switch
      i_req = 8'h00;
      tick();
      tick();
      chk_st("idle", 8'h00, 3'd0, 1'b0, 1'b0);
      i_opt = 1'b0;
      i_req = 8'h10;
      tick();
      chk_st("g4_cold", 8'hEF, 3'd4, 1'b1, 1'b0);
      i_req = 8'hFF;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_st("nopreempt", 8'hEF, 3'd4, 1'b1, 1'b0);
      end
      i_opt = 1'b1;
      #1;
      chk("opt_flip", o_gnt, 8'h10);

      // Release, then same requester re-raises in the GAP as the only one
      i_req = 8'h00;
      tick();
      chk_st("gap4", 8'h00, 3'd4, 1'b0, 1'b0);
      i_req = 8'h10;
      tick();
      chk_st("g4_again", 8'h10, 3'd4, 1'b1, 1'b0);

      // Lowest priority to the one that just released: ptr=5 picks 5 over 4
      i_req = 8'h30;
      tick();
      chk_st("hold4", 8'h10, 3'd4, 1'b1, 1'b0);
      i_req = 8'h20;
      tick();
      chk_st("gap4b", 8'h00, 3'd4, 1'b0, 1'b0);
      i_req = 8'h30;
      tick();
      chk_st("g5", 8'h20, 3'd5, 1'b1, 1'b0);

      // Mid-tenure reset returns the pointer to 0
      i_req = 8'h21;
      tick();
      chk_st("hold5", 8'h20, 3'd5, 1'b1, 1'b0);
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      chk_st("rst_mid", 8'h00, 3'd0, 1'b0, 1'b0);
      tick();
      chk_st("g0_after_rst", 8'h01, 3'd0, 1'b1, 1'b0);
      i_req = 8'h00;
      tick();
      tick();

`ifdef SEL8_ARB_TIMEOUT_EN
      // Constant request: 16 grant cycles, one timeout GAP, then repeat
      i_req = 8'h04;
      tick();
      for (int r = 0; r < 2; r++) begin
         for (int k = 1; k <= 16; k++) begin
            chk_st("tmo_hold", 8'h04, 3'd2, 1'b1, 1'b0);
            if (k < 16) tick();
         end
         tick();
         chk_st("tmo_gap", 8'h00, 3'd2, 1'b0, 1'b1);
         tick();
      end
      chk_st("tmo_regrant", 8'h04, 3'd2, 1'b1, 1'b0);
      for (int k = 0; k < 15; k++) tick();
      chk_st("tmo_last", 8'h04, 3'd2, 1'b1, 1'b0);
      i_req = 8'h00;
      tick();
      chk_st("rel_at_limit", 8'h00, 3'd2, 1'b0, 1'b0);
`else
      // Without the timeout a tenure is unbounded
      i_req = 8'h04;
      tick();
      for (int k = 0; k < 20; k++) tick();
      chk_st("long_hold", 8'h04, 3'd2, 1'b1, 1'b0);
      i_req = 8'h00;
      tick();
      chk_st("long_rel", 8'h00, 3'd2, 1'b0, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
